mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Pipeline stage directly downstream of the execute stage. Consumes the EX
//  pipeline register (instr, imm, rs/rt values, dest reg, opcode, ALU result, pc).
//  Performs data-memory access for `LDW/`SDW against an internal word-addressed
//  data RAM with configurable multi-cycle latency, stalling upstream while busy.
//  Registers results for the write-back stage.
// PARAMETERS
//  MEM_DEPTH  1024  data RAM depth in 32-bit words (power of 2)
//  ADDR_W     10    log2(MEM_DEPTH); word-index width
//  MEM_LAT    2     cycles per memory access (>=1); 1 = no stall
// PORTS
//  clk           in   1   clock, rising edge
//  rst_n         in   1   asynchronous active-low reset
//  instr_in      in   32  instruction from EX
//  imm_in        in   32  immediate from EX
//  val_rs_in     in   32  rs value from EX
//  val_rt_in     in   32  rt value from EX; store data for `SDW
//  rwd_in        in   5   destination register from EX
//  opcode_in     in   6   opcode from EX (`def.v` encodings)
//  alu_res_in    in   32  ALU result from EX; byte address for `LDW/`SDW
//  pc_in         in   32  pc from EX
//  stall_out     out  1   hold EX/earlier stages; combinational
//  instr_out     out  32  registered instr to WB
//  rwd_out       out  5   registered destination register
//  opcode_out    out  6   registered opcode
//  alu_res_out   out  32  registered ALU result
//  mem_data_out  out  32  registered load data (0 for non-`LDW)
//  pc_out        out  32  registered pc
// BEHAVIOUR
//  - Async reset (rst_n=0): all outputs 0, access counter cnt=0 (state IDLE),
//    stall_out=0. RAM contents are not cleared.
//  - is_mem = (opcode_in==`LDW)||(opcode_in==`SDW). Word index = alu_res_in[ADDR_W+1:2];
//    bits [1:0] ignored; higher bits ignored (address wraps modulo MEM_DEPTH).
//  - Non-memory op: 1-cycle latency; outputs load inputs on next edge,
//    mem_data_out<=0, stall_out=0.
//  - Memory op: access spans MEM_LAT cycles, cnt=0..MEM_LAT-1.
//    stall_out = is_mem && (cnt != MEM_LAT-1). cnt increments each edge while
//    stalled; returns to 0 on the completing edge. States: IDLE (cnt==0),
//    BUSY (cnt>0).
//  - Upstream holds all *_in stable while stall_out=1 (EX contract).
//  - While stall_out=1, each edge loads a bubble: instr/rwd/opcode/alu_res/
//    mem_data/pc outputs all 0.
//  - Completing edge (cnt==MEM_LAT-1): `SDW writes val_rt_in to RAM[index];
//    `LDW loads mem_data_out<=RAM[index]; all other outputs load inputs.
//  - Back-to-back: a `LDW immediately after an `SDW to the same word returns the
//    stored value (store committed at the earlier completing edge).
//  - Reset asserted mid-access: access aborted, cnt=0, no RAM write occurs,
//    stall_out=0 during reset.
//  - MEM_LAT=1: stall_out is constant 0; memory ops complete in 1 cycle.
// TESTING
//  1. Reset: rst_n=0 mid-cycle -> all outputs 0 and stall_out=0 immediately
//     (async).
//  2. ADD op, alu_res_in=32'h5, rwd_in=3 -> next edge alu_res_out=5, rwd_out=3,
//     mem_data_out=0, stall_out never high.
//  3. MEM_LAT=2: `SDW alu_res_in=32'h10, val_rt_in=32'hDEADBEEF -> stall_out=1
//     for 1 cycle, one bubble, then opcode_out=`SDW; then `LDW addr 32'h10 ->
//     mem_data_out=32'hDEADBEEF after 2 edges.
//  4. Wrap: `SDW addr 32'h1010 (index 4 with ADDR_W=10, bits above wrap), data
//     32'h1234; `LDW addr 32'h10 -> mem_data_out=32'h1234.
//  5. Reset during BUSY of an `SDW to addr 32'h20 (MEM_LAT=3, after 1 cycle) ->
//     stall_out=0, outputs 0; later `LDW 32'h20 returns the prior contents,
//     not the store data.
//  6. MEM_LAT=1: `LDW/`SDW stream -> stall_out stays 0, one result per cycle.

Source files
------------

// File: rtl/mem_stage.sv
// Memory pipeline stage: word-addressed data RAM with MEM_LAT-cycle accesses,
// stalling upstream while busy and registering results for write-back.
module mem_stage #(
    parameter int          MEM_DEPTH = 1024,
    parameter int          ADDR_W    = 10,
    parameter int          MEM_LAT   = 2,
    parameter logic [5:0]  OP_LDW    = 6'h23,
    parameter logic [5:0]  OP_SDW    = 6'h2B
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_in,
    input  logic [31:0] imm_in,
    input  logic [31:0] val_rs_in,
    input  logic [31:0] val_rt_in,
    input  logic [4:0]  rwd_in,
    input  logic [5:0]  opcode_in,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] pc_in,
    output logic        stall_out,
    output logic [31:0] instr_out,
    output logic [4:0]  rwd_out,
    output logic [5:0]  opcode_out,
    output logic [31:0] alu_res_out,
    output logic [31:0] mem_data_out,
    output logic [31:0] pc_out
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    logic [31:0]       mem [MEM_DEPTH];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] word_idx;
    logic              is_ldw, is_sdw, is_mem, last_cycle, ram_we;

    logic [31:0] instr_q, alu_res_q, mem_data_q, pc_q;
    logic [4:0]  rwd_q;
    logic [5:0]  opcode_q;

    // EX forwards these for other consumers; this stage has no use for them.
    logic unused_ok;
    assign unused_ok = ^{imm_in, val_rs_in};

    assign is_ldw     = (opcode_in == OP_LDW);
    assign is_sdw     = (opcode_in == OP_SDW);
    assign is_mem     = is_ldw || is_sdw;
    assign word_idx   = alu_res_in[ADDR_W+1:2];
    assign last_cycle = (cnt_q == CNT_LAST);

    // Held low during reset so an in-flight access cannot freeze upstream.
    assign stall_out  = rst_n && is_mem && !last_cycle;
    assign ram_we     = rst_n && is_sdw && last_cycle;

    always_comb begin
        cnt_d = '0;
        if (stall_out) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // RAM has no reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[word_idx] <= val_rt_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= '0;
            rwd_q      <= '0;
            opcode_q   <= '0;
            alu_res_q  <= '0;
            mem_data_q <= '0;
            pc_q       <= '0;
        end else if (stall_out) begin
            instr_q    <= '0;
            rwd_q      <= '0;
            opcode_q   <= '0;
            alu_res_q  <= '0;
            mem_data_q <= '0;
            pc_q       <= '0;
        end else begin
            instr_q    <= instr_in;
            rwd_q      <= rwd_in;
            opcode_q   <= opcode_in;
            alu_res_q  <= alu_res_in;
            mem_data_q <= is_ldw ? mem[word_idx] : 32'd0;
            pc_q       <= pc_in;
        end
    end

    assign instr_out    = instr_q;
    assign rwd_out      = rwd_q;
    assign opcode_out   = opcode_q;
    assign alu_res_out  = alu_res_q;
    assign mem_data_out = mem_data_q;
    assign pc_out       = pc_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: three instances at MEM_LAT 2, 3 and 1,
// driven by directed vectors, checked by per-instance output monitors.
module tb_mem_stage;

    localparam logic [5:0] OP_ADD = 6'h20;
    localparam logic [5:0] OP_LDW = 6'h23;
    localparam logic [5:0] OP_SDW = 6'h2B;
    localparam int LATS [3] = '{2, 3, 1};

    typedef struct {
        int          inst;
        logic [31:0] instr;
        logic [4:0]  rwd;
        logic [5:0]  op;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_in [3];
    logic [31:0] imm_in [3];
    logic [31:0] val_rs_in [3];
    logic [31:0] val_rt_in [3];
    logic [4:0]  rwd_in [3];
    logic [5:0]  opcode_in [3];
    logic [31:0] alu_res_in [3];
    logic [31:0] pc_in [3];
    logic        stall_out [3];
    logic [31:0] instr_out [3];
    logic [4:0]  rwd_out [3];
    logic [5:0]  opcode_out [3];
    logic [31:0] alu_res_out [3];
    logic [31:0] mem_data_out [3];
    logic [31:0] pc_out [3];

    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        mem_stage #(
            .MEM_DEPTH(1024), .ADDR_W(10), .MEM_LAT(LATS[gi]),
            .OP_LDW(OP_LDW), .OP_SDW(OP_SDW)
        ) dut (
            .clk(clk), .rst_n(rst_n),
            .instr_in(instr_in[gi]), .imm_in(imm_in[gi]),
            .val_rs_in(val_rs_in[gi]), .val_rt_in(val_rt_in[gi]),
            .rwd_in(rwd_in[gi]), .opcode_in(opcode_in[gi]),
            .alu_res_in(alu_res_in[gi]), .pc_in(pc_in[gi]),
            .stall_out(stall_out[gi]), .instr_out(instr_out[gi]),
            .rwd_out(rwd_out[gi]), .opcode_out(opcode_out[gi]),
            .alu_res_out(alu_res_out[gi]), .mem_data_out(mem_data_out[gi]),
            .pc_out(pc_out[gi])
        );

        // Any non-zero instr_out is a real result; zeros are bubbles or idle.
        always @(negedge clk) begin
            if (rst_n && instr_out[gi] != 32'd0) begin
                if (sb_q.size() == 0) begin
                    chk($sformatf("unexpected_result_u%0d", gi), instr_out[gi], 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk($sformatf("result_unit_u%0d", gi), gi, e.inst);
                    chk($sformatf("instr_u%0d", gi), instr_out[gi], e.instr);
                    chk($sformatf("rwd_u%0d", gi), {27'd0, rwd_out[gi]}, {27'd0, e.rwd});
                    chk($sformatf("opcode_u%0d", gi), {26'd0, opcode_out[gi]}, {26'd0, e.op});
                    chk($sformatf("alu_res_u%0d", gi), alu_res_out[gi], e.alu);
                    chk($sformatf("mem_data_u%0d", gi), mem_data_out[gi], e.mem);
                    chk($sformatf("pc_u%0d", gi), pc_out[gi], e.pc);
                end
            end
        end
    end

    task automatic idle(input int k);
        instr_in[k] = '0; imm_in[k] = '0; val_rs_in[k] = '0; val_rt_in[k] = '0;
        rwd_in[k] = '0; opcode_in[k] = '0; alu_res_in[k] = '0; pc_in[k] = '0;
    endtask

    // Called one time unit after a rising edge; returns likewise after the completing edge.
    task automatic issue(input int k, input logic [31:0] instr, input logic [5:0] op,
                         input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] rwd,
                         input logic [31:0] pc, input logic [31:0] exp_mem);
        exp_t e;
        int stalls;
        bit done;
        instr_in[k] = instr; opcode_in[k] = op; alu_res_in[k] = alu;
        val_rt_in[k] = rt; rwd_in[k] = rwd; pc_in[k] = pc;
        imm_in[k] = 32'h0000_0011; val_rs_in[k] = 32'h0000_0022;
        e.inst = k; e.instr = instr; e.rwd = rwd; e.op = op;
        e.alu = alu; e.mem = exp_mem; e.pc = pc;
        sb_q.push_back(e);
        stalls = 0;
        done = 1'b0;
        for (int c = 0; c < 8 && !done; c++) begin
            @(negedge clk);
            if (stall_out[k]) stalls++;
            else done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) chk($sformatf("stall_timeout_u%0d", k), 32'd1, 32'd0);
        chk($sformatf("stall_cycles_u%0d_pc%h", k, pc), stalls,
            (op == OP_LDW || op == OP_SDW) ? LATS[k] - 1 : 0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) idle(k);

        // Outputs must be zero while reset is held, before any clock edge.
        #2;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("por_alu_u%0d", k), alu_res_out[k], 32'd0);
            chk($sformatf("por_stall_u%0d", k), {31'd0, stall_out[k]}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset mid-cycle clears loaded outputs immediately.
        opcode_in[0] = OP_ADD; alu_res_in[0] = 32'h5; rwd_in[0] = 5'd3; pc_in[0] = 32'h200;
        @(posedge clk);
        #2;
        chk("pre_reset_alu", alu_res_out[0], 32'h5);
        rst_n = 1'b0;
        #1;
        chk("async_alu", alu_res_out[0], 32'd0);
        chk("async_rwd", {27'd0, rwd_out[0]}, 32'd0);
        chk("async_opcode", {26'd0, opcode_out[0]}, 32'd0);
        chk("async_pc", pc_out[0], 32'd0);
        chk("async_stall", {31'd0, stall_out[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(0);
        @(posedge clk);
        #1;

        // MEM_LAT=2: ALU op, store/load, back-to-back, address wrap.
        issue(0, 32'h0000_1001, OP_ADD, 32'h5, 32'h0, 5'd3, 32'h100, 32'h0);
        issue(0, 32'h0000_1002, OP_SDW, 32'h10, 32'hDEADBEEF, 5'd0, 32'h104, 32'h0);
        issue(0, 32'h0000_1003, OP_LDW, 32'h10, 32'h0, 5'd7, 32'h108, 32'hDEADBEEF);
        issue(0, 32'h0000_1004, OP_SDW, 32'h1010, 32'h1234, 5'd0, 32'h10C, 32'h0);
        issue(0, 32'h0000_1005, OP_LDW, 32'h10, 32'h0, 5'd8, 32'h110, 32'h1234);
        issue(0, 32'h0000_1006, OP_LDW, 32'h13, 32'h0, 5'd9, 32'h114, 32'h1234);
        idle(0);
        repeat (2) @(posedge clk);
        #1;

        // MEM_LAT=3: committed store, then a store aborted by reset.
        issue(1, 32'h0000_2001, OP_SDW, 32'h20, 32'hAAAA5555, 5'd0, 32'h300, 32'h0);
        instr_in[1] = 32'h0000_2002; opcode_in[1] = OP_SDW; alu_res_in[1] = 32'h20;
        val_rt_in[1] = 32'hBBBB0000; pc_in[1] = 32'h304;
        @(posedge clk);
        #1;
        chk("busy_stall_u1", {31'd0, stall_out[1]}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_stall_u1", {31'd0, stall_out[1]}, 32'd0);
        chk("abort_pc_u1", pc_out[1], 32'd0);
        chk("abort_opcode_u1", {26'd0, opcode_out[1]}, 32'd0);
        @(posedge clk);
        #1;
        chk("reset_edge_stall_u1", {31'd0, stall_out[1]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        @(posedge clk);
        #1;
        issue(1, 32'h0000_2003, OP_LDW, 32'h20, 32'h0, 5'd4, 32'h308, 32'hAAAA5555);
        issue(1, 32'h0000_2004, OP_ADD, 32'h77, 32'h0, 5'd5, 32'h30C, 32'h0);
        idle(1);
        repeat (2) @(posedge clk);
        #1;

        // MEM_LAT=1: memory stream completes one per cycle, no stall.
        issue(2, 32'h0000_3001, OP_SDW, 32'h40, 32'h11111111, 5'd0, 32'h400, 32'h0);
        issue(2, 32'h0000_3002, OP_SDW, 32'h44, 32'h22222222, 5'd0, 32'h404, 32'h0);
        issue(2, 32'h0000_3003, OP_LDW, 32'h40, 32'h0, 5'd1, 32'h408, 32'h11111111);
        issue(2, 32'h0000_3004, OP_LDW, 32'h44, 32'h0, 5'd2, 32'h40C, 32'h22222222);
        issue(2, 32'h0000_3005, OP_SDW, 32'h40, 32'h33333333, 5'd0, 32'h410, 32'h0);
        issue(2, 32'h0000_3006, OP_LDW, 32'h40, 32'h0, 5'd6, 32'h414, 32'h33333333);
        idle(2);
        repeat (3) @(posedge clk);
        #1;

        chk("scoreboard_drained", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
